// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for the two-port RAM arbiter.
// Port 0 and port 1 share the same request/acknowledge shape.
interface ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;
  logic          err0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;
  logic          err1;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters.
// One registered bus cycle per grant, one-cycle ack with read data.
module ram_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  state_t        state_q, state_d;
  logic          last_q;
  logic          win_q, win_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          grant;

  logic          ack0_q, ack1_q;
  logic          err0_q, err1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic          elig0, elig1;
  logic          xfer, in_rng;

  // A port still holding req during its own ack cycle is not eligible.
  assign elig0  = bus.req0 & ~ack0_q;
  assign elig1  = bus.req1 & ~ack1_q;
  assign xfer   = (state_q == XFER);
  assign in_rng = (addr_q < LIMIT);

  // Next state and winner selection; the port that did not win last time wins ties.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          grant   = 1'b1;
          state_d = XFER;
          unique case (1'b1)
            elig0 & elig1:  win_d = ~last_q;
            elig1 & ~elig0: win_d = 1'b1;
            elig0 & ~elig1: win_d = 1'b0;
            default:        win_d = 1'b0;
          endcase
        end
      end
      XFER: state_d = IDLE;
    endcase
  end

  // State register; async reset aborts an in-flight cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Capture the winning request so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      last_q  <= win_d;
      win_q   <= win_d;
      we_q    <= win_d ? bus.we1    : bus.we0;
      addr_q  <= win_d ? bus.addr1  : bus.addr0;
      wdata_q <= win_d ? bus.wdata1 : bus.wdata0;
    end
  end

  // Completion pulses and read data returned at the end of the bus cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= xfer & ~win_q;
      ack1_q <= xfer &  win_q;
      err0_q <= xfer & ~win_q & ~in_rng;
      err1_q <= xfer &  win_q & ~in_rng;
      if (xfer & ~we_q & ~win_q)
        rdata0_q <= in_rng ? mem_data : '0;
      if (xfer & ~we_q & win_q)
        rdata1_q <= in_rng ? mem_data : '0;
    end
  end

  // RAM bus: only an in-range write drives the shared data lines.
  assign mem_addr = xfer ? addr_q : '0;
  assign mem_we   = xfer & we_q & in_rng;
  assign mem_data = mem_we ? wdata_q : {DW{1'bz}};

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.err0   = err0_q;
  assign bus.err1   = err1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction model plus directed masters.
// A RAM model drives mem_data whenever the arbiter is not writing.
module tb_ram_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        v;
    logic        p;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic [DW-1:0] ram [DEPTH];

  ram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  assign mem_data = mem_we ? {DW{1'bz}} : ram[mem_addr[9:0]];

  always @(posedge clk)
    if (mem_we) ram[mem_addr[9:0]] <= mem_data;

  // Transaction-level reference
  txn_t        cur_t;
  logic [1:0]  e_ack, e_err;
  logic [31:0] e_rd0, e_rd1;
  logic        m_last;
  logic [31:0] m_ram [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    txn_t       nx;
    logic [1:0] nack, nerr;
    logic       k, inr, el0, el1, win;
    nx   = '0;
    nack = 2'b00;
    nerr = 2'b00;
    if (cur_t.v) begin
      k       = cur_t.p;
      inr     = cur_t.a < DEPTH;
      nack[k] = 1'b1;
      nerr[k] = ~inr;
      if (!cur_t.w) begin
        if (k) e_rd1 <= inr ? m_ram[cur_t.a[9:0]] : 32'h0;
        else   e_rd0 <= inr ? m_ram[cur_t.a[9:0]] : 32'h0;
      end else if (inr) begin
        m_ram[cur_t.a[9:0]] <= cur_t.d;
      end
    end else begin
      el0 = bus.req0 && !e_ack[0];
      el1 = bus.req1 && !e_ack[1];
      if (el0 || el1) begin
        win    = (el0 && el1) ? ~m_last : el1;
        m_last <= win;
        nx.v   = 1'b1;
        nx.p   = win;
        nx.w   = win ? bus.we1    : bus.we0;
        nx.a   = win ? bus.addr1  : bus.addr0;
        nx.d   = win ? bus.wdata1 : bus.wdata0;
      end
    end
    e_ack <= nack;
    e_err <= nerr;
    cur_t <= nx;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_t  <= '0;
      e_ack  <= 2'b00;
      e_err  <= 2'b00;
      e_rd0  <= 32'h0;
      e_rd1  <= 32'h0;
      m_last <= 1'b1;
    end else begin
      model_step();
    end
  end

  wire [31:0] ea = cur_t.v ? cur_t.a : 32'h0;
  wire        ew = cur_t.v && cur_t.w && (cur_t.a < DEPTH);
  wire [31:0] ed = ew ? cur_t.d : m_ram[ea[9:0]];

  // Cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("ack0", 32'(bus.ack0), 32'(e_ack[0]));
    chk("ack1", 32'(bus.ack1), 32'(e_ack[1]));
    chk("err0", 32'(bus.err0), 32'(e_err[0]));
    chk("err1", 32'(bus.err1), 32'(e_err[1]));
    chk("rdata0", bus.rdata0, e_rd0);
    chk("rdata1", bus.rdata1, e_rd1);
    chk("mem_we", 32'(mem_we), 32'(ew));
    chk("mem_addr", mem_addr, ea);
    chk("mem_data", mem_data, ed);
  end

  task automatic drv(input logic p, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  function automatic logic ack_of(input logic p);
    return p ? bus.ack1 : bus.ack0;
  endfunction

  // Master holding req across n transactions; checks latency and results
  task automatic run_port(input logic p, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input int n, input logic inc,
                          input int lat1, input int latn,
                          input logic [31:0] exp_rd, input logic exp_e);
    int cnt;
    int off;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      off = inc ? i : 0;
      drv(p, 1'b1, w, a + 32'(off), d + 32'(off));
      cnt = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
      end while (!ack_of(p) && cnt < 20);
      chk(p ? "p1_ack_seen" : "p0_ack_seen", 32'(ack_of(p)), 32'd1);
      chk(p ? "p1_latency" : "p0_latency", 32'(cnt),
          32'(i == 0 ? lat1 : latn));
      chk(p ? "p1_err" : "p0_err",
          32'(p ? bus.err1 : bus.err0), 32'(exp_e));
      if (!w)
        chk(p ? "p1_rdata" : "p0_rdata",
            p ? bus.rdata1 : bus.rdata0, exp_rd);
    end
    drv(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = '0;
      m_ram[i] = '0;
    end
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(bus.ack0), 32'd0);
    chk("rst_ack1", 32'(bus.ack1), 32'd0);
    chk("rst_err0", 32'(bus.err0), 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_mem_we", 32'(mem_we), 32'd0);

    run_port(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1, 1'b0, 2, 2, 32'h0, 1'b0);
    run_port(1'b1, 1'b0, 32'd5, 32'h0, 1, 1'b0, 2, 2, 32'hDEADBEEF, 1'b0);

    run_port(1'b0, 1'b1, 32'd1, 32'h11, 1, 1'b0, 2, 2, 32'h0, 1'b0);
    run_port(1'b1, 1'b1, 32'd2, 32'h22, 1, 1'b0, 2, 2, 32'h0, 1'b0);
    fork
      run_port(1'b0, 1'b0, 32'd1, 32'h0, 10, 1'b0, 2, 4, 32'h11, 1'b0);
      run_port(1'b1, 1'b0, 32'd2, 32'h0, 10, 1'b0, 4, 4, 32'h22, 1'b0);
    join

    run_port(1'b0, 1'b1, 32'd0, 32'hA0, 4, 1'b1, 2, 3, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_port(1'b1, 1'b0, 32'(i), 32'h0, 1, 1'b0, 2, 2,
               32'hA0 + 32'(i), 1'b0);

    run_port(1'b0, 1'b1, 32'd1024, 32'hBAD, 1, 1'b0, 2, 2, 32'h0, 1'b1);
    run_port(1'b0, 1'b0, 32'd0, 32'h0, 1, 1'b0, 2, 2, 32'hA0, 1'b0);
    run_port(1'b0, 1'b0, 32'd2000, 32'h0, 1, 1'b0, 2, 2, 32'h0, 1'b1);

    run_port(1'b0, 1'b1, 32'd7, 32'h77, 1, 1'b0, 2, 2, 32'h0, 1'b0);
    @(posedge clk); #1;
    drv(1'b0, 1'b1, 1'b1, 32'd7, 32'h5A);
    @(posedge clk); #1;
    chk("xfer_mem_we", 32'(mem_we), 32'd1);
    chk("xfer_mem_addr", mem_addr, 32'd7);
    chk("xfer_mem_data", mem_data, 32'h5A);
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_data", mem_data, 32'hA0);
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_ack0", 32'(bus.ack0), 32'd0);
    rst = 1'b1;
    run_port(1'b0, 1'b0, 32'd7, 32'h0, 1, 1'b0, 2, 2, 32'h77, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
